// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the L1 writeback (dirty-line
// eviction) engine.
//   - geometry: BEATS x DATA_W line, ADDR_W physical address
//   - TileLink C/D opcodes used by the engine
//   - FSM state enum and the arbitrated request struct
//   - line_addr(): line-aligned address {tag, idx, offset=0}
package wb_pkg;

  localparam int BEATS        = 8;
  localparam int DATA_W       = 64;
  localparam int ADDR_W       = 32;
  localparam int BEAT_W       = $clog2(BEATS);
  // One extra bit so counters can hold the value BEATS (all beats done).
  localparam int CNT_W        = BEAT_W + 1;
  localparam int TAG_W        = 20;
  localparam int IDX_W        = 6;
  localparam int SRC_W        = 2;
  localparam int PARAM_W      = 3;
  localparam int WAYS         = 4;
  localparam int LINE_SIZE_LG = 6;

  localparam logic [2:0] PROBE_ACK_DATA = 3'h5;
  localparam logic [2:0] RELEASE_DATA   = 3'h7;
  localparam logic [2:0] RELEASE_ACK    = 3'h6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_WAIT_ACK = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   idx;
    logic [SRC_W-1:0]   source;
    logic [PARAM_W-1:0] param;
    logic [WAYS-1:0]    way_en;
    logic               voluntary;
  } wb_req_t;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
    return {tag, idx, {LINE_SIZE_LG{1'b0}}};
  endfunction

endpackage

// File: rtl/wb_beat_buffer.sv
// wb_beat_buffer: BEATS x DATA_W line buffer between the data-array read
// side and the C-channel send side of the writeback engine.
//   clock       : write clock (rising edge)
//   wr_en/idx   : write one beat at wr_idx
//   wr_data     : beat data
//   rd_idx      : combinational read index
//   rd_data     : beat data at rd_idx
// WRITEBACK_PARITY_EN adds a per-beat corrupt flag (wr_corrupt/rd_corrupt).
// Storage is not reset: a beat is always written before it is read.
module wb_beat_buffer
  import wb_pkg::*;
(
  input  logic              clock,
  input  logic              wr_en,
  input  logic [BEAT_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_data,
`ifdef WRITEBACK_PARITY_EN
  input  logic              wr_corrupt,
  output logic              rd_corrupt,
`endif
  input  logic [BEAT_W-1:0] rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [BEATS-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

`ifdef WRITEBACK_PARITY_EN
  logic [BEATS-1:0] bad;

  always_ff @(posedge clock) begin
    if (wr_en) bad[wr_idx] <= wr_corrupt;
  end

  assign rd_corrupt = bad[rd_idx];
`endif

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: dirty-line eviction engine for the L1 data cache.
// Accepts one arbitrated writeback/probe request, reads the BEATS beats of
// the victim line from the data array and streams them on TileLink C as
// ReleaseData (voluntary) or ProbeAckData (probe). Voluntary releases then
// wait for ReleaseAck on D before the next request is accepted.
// Ports:
//   clock, reset          : clock; reset is asynchronous, active-low
//   io_req_*              : arbitrated request (ready only in IDLE)
//   io_idx_valid/bits     : set being evicted (valid whenever busy)
//   io_data_req_*         : data-array read request {idx, beat}
//   io_data_resp          : read data, one cycle after a data_req handshake
//   io_mem_c_*            : TileLink C channel output
//   io_mem_d_*            : TileLink D channel (ReleaseAck) input
// Optional feature macro WRITEBACK_PARITY_EN adds io_data_resp_parity and
// io_parity_err; beats with bad parity go out with c_bits_corrupt=1.
// Without it c_bits_corrupt is tied to 0.
module writeback_unit
  import wb_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  output logic               io_req_ready,
  input  logic               io_req_valid,
  input  logic [TAG_W-1:0]   io_req_bits_tag,
  input  logic [IDX_W-1:0]   io_req_bits_idx,
  input  logic [SRC_W-1:0]   io_req_bits_source,
  input  logic [PARAM_W-1:0] io_req_bits_param,
  input  logic [WAYS-1:0]    io_req_bits_way_en,
  input  logic               io_req_bits_voluntary,
  output logic               io_idx_valid,
  output logic [IDX_W-1:0]   io_idx_bits,
  output logic               io_data_req_valid,
  input  logic               io_data_req_ready,
  output logic [WAYS-1:0]    io_data_req_bits_way_en,
  output logic [IDX_W+BEAT_W-1:0] io_data_req_bits_addr,
  input  logic [DATA_W-1:0]  io_data_resp,
`ifdef WRITEBACK_PARITY_EN
  input  logic               io_data_resp_parity,
  output logic               io_parity_err,
`endif
  input  logic               io_mem_c_ready,
  output logic               io_mem_c_valid,
  output logic [2:0]         io_mem_c_bits_opcode,
  output logic [PARAM_W-1:0] io_mem_c_bits_param,
  output logic [3:0]         io_mem_c_bits_size,
  output logic [SRC_W-1:0]   io_mem_c_bits_source,
  output logic [ADDR_W-1:0]  io_mem_c_bits_address,
  output logic [DATA_W-1:0]  io_mem_c_bits_data,
  output logic               io_mem_c_bits_corrupt,
  input  logic               io_mem_d_valid,
  output logic               io_mem_d_ready,
  input  logic [2:0]         io_mem_d_bits_opcode
);

  wb_state_e         state;
  wb_req_t           req_in, req_q;
  logic [CNT_W-1:0]  r_cnt, s_cnt, filled, unsent, avail;
  logic              resp_pend;
  logic [BEAT_W-1:0] resp_idx;
  logic              data_req_fire, c_fire, c_last, bypass;
  logic [DATA_W-1:0] buf_data, beat_data;

  assign req_in = '{tag:       io_req_bits_tag,
                    idx:       io_req_bits_idx,
                    source:    io_req_bits_source,
                    param:     io_req_bits_param,
                    way_en:    io_req_bits_way_en,
                    voluntary: io_req_bits_voluntary};

  // Reads issued but not yet sent, including a response still in flight.
  // Capping this at two keeps reads from running ahead of a stalled C.
  assign unsent = r_cnt - s_cnt;
  // Beats the send side may use: captured ones plus the one on data_resp now.
  assign avail  = filled + CNT_W'(resp_pend);

  assign io_data_req_valid = (state == ST_ACTIVE) && (r_cnt < CNT_W'(BEATS)) &&
                             (unsent < CNT_W'(2));
  assign data_req_fire     = io_data_req_valid && io_data_req_ready;

  assign io_mem_c_valid = (state == ST_ACTIVE) && (s_cnt < avail);
  assign c_fire         = io_mem_c_valid && io_mem_c_ready;
  assign c_last         = c_fire && (s_cnt == CNT_W'(BEATS-1));

  // The beat arriving this cycle is the next to send: forward it straight
  // from data_resp. If C stalls, the same beat is read back from the buffer
  // next cycle, so the C bits stay stable.
  assign bypass    = resp_pend && (s_cnt == filled);
  assign beat_data = bypass ? io_data_resp : buf_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      req_q     <= '0;
      r_cnt     <= '0;
      s_cnt     <= '0;
      filled    <= '0;
      resp_pend <= 1'b0;
      resp_idx  <= '0;
    end else begin
      resp_pend <= data_req_fire;
      if (data_req_fire) resp_idx <= r_cnt[BEAT_W-1:0];
      case (state)
        ST_IDLE: begin
          if (io_req_valid) begin
            req_q  <= req_in;
            r_cnt  <= '0;
            s_cnt  <= '0;
            filled <= '0;
            state  <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (data_req_fire) r_cnt  <= r_cnt + CNT_W'(1);
          if (resp_pend)     filled <= filled + CNT_W'(1);
          if (c_fire)        s_cnt  <= s_cnt + CNT_W'(1);
          if (c_last)        state  <= req_q.voluntary ? ST_WAIT_ACK : ST_IDLE;
        end
        ST_WAIT_ACK: begin
          // Any non-ReleaseAck on D is consumed and dropped.
          if (io_mem_d_valid && (io_mem_d_bits_opcode == RELEASE_ACK))
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef WRITEBACK_PARITY_EN
  logic resp_corrupt, buf_corrupt;

  assign resp_corrupt  = (^io_data_resp) != io_data_resp_parity;
  assign io_parity_err = resp_pend && resp_corrupt;

  wb_beat_buffer u_buf (
    .clock      (clock),
    .wr_en      (resp_pend),
    .wr_idx     (resp_idx),
    .wr_data    (io_data_resp),
    .wr_corrupt (resp_corrupt),
    .rd_corrupt (buf_corrupt),
    .rd_idx     (s_cnt[BEAT_W-1:0]),
    .rd_data    (buf_data)
  );

  assign io_mem_c_bits_corrupt = io_mem_c_valid && (bypass ? resp_corrupt : buf_corrupt);
`else
  wb_beat_buffer u_buf (
    .clock   (clock),
    .wr_en   (resp_pend),
    .wr_idx  (resp_idx),
    .wr_data (io_data_resp),
    .rd_idx  (s_cnt[BEAT_W-1:0]),
    .rd_data (buf_data)
  );

  assign io_mem_c_bits_corrupt = 1'b0;
`endif

  // req_ready is gated by reset so it reads 0 while reset is held.
  assign io_req_ready            = (state == ST_IDLE) && reset;
  assign io_idx_valid            = (state != ST_IDLE);
  assign io_idx_bits             = req_q.idx;
  assign io_mem_d_ready          = (state == ST_WAIT_ACK);
  assign io_data_req_bits_way_en = req_q.way_en;
  assign io_data_req_bits_addr   = {req_q.idx, r_cnt[BEAT_W-1:0]};

  // C bits are zero whenever no beat is offered.
  assign io_mem_c_bits_opcode  = !io_mem_c_valid ? 3'h0 :
                                 req_q.voluntary ? RELEASE_DATA : PROBE_ACK_DATA;
  assign io_mem_c_bits_param   = io_mem_c_valid ? req_q.param : '0;
  assign io_mem_c_bits_size    = io_mem_c_valid ? 4'(LINE_SIZE_LG) : 4'd0;
  assign io_mem_c_bits_source  = io_mem_c_valid ? req_q.source : '0;
  assign io_mem_c_bits_address = io_mem_c_valid ? line_addr(req_q.tag, req_q.idx) : '0;
  assign io_mem_c_bits_data    = io_mem_c_valid ? beat_data : '0;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit. A data-array model answers reads one
// cycle after each handshake; a scoreboard derives every C beat from the
// request fields and the array contents and checks each beat, C-bit
// stability under backpressure and the read-ahead bound. Inputs are driven
// 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_writeback_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_ready, req_valid;
  logic [19:0] req_tag;
  logic [5:0]  req_idx;
  logic [1:0]  req_source;
  logic [2:0]  req_param;
  logic [3:0]  req_way_en;
  logic        req_vol;
  logic        idx_valid;
  logic [5:0]  idx_bits;
  logic        dr_valid, dr_ready;
  logic [3:0]  dr_way_en;
  logic [8:0]  dr_addr;
  logic [63:0] data_resp;
  logic        c_ready, c_valid;
  logic [2:0]  c_opcode, c_param;
  logic [3:0]  c_size;
  logic [1:0]  c_source;
  logic [31:0] c_address;
  logic [63:0] c_data;
  logic        c_corrupt;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode;
`ifdef WRITEBACK_PARITY_EN
  logic        resp_parity, parity_err;
  int          bad_beat = -1;
`endif

  int checks = 0, failures = 0;
  int cyc = 0;
  int nb = 0, nr = 0, perr_cnt = 0, acc = 0;
  int beat_cyc[8];
  logic        exp_active = 1'b0;
  logic [19:0] exp_tag;
  logic [5:0]  exp_idx;
  logic [1:0]  exp_src;
  logic [2:0]  exp_param;
  logic [3:0]  exp_way;
  logic        exp_vol;
  logic        c_toggle = 1'b0;
  logic [63:0] first_data;
  logic [31:0] first_addr;
  logic [2:0]  first_op;

  writeback_unit dut (
    .clock                   (clock),
    .reset                   (reset),
    .io_req_ready            (req_ready),
    .io_req_valid            (req_valid),
    .io_req_bits_tag         (req_tag),
    .io_req_bits_idx         (req_idx),
    .io_req_bits_source      (req_source),
    .io_req_bits_param       (req_param),
    .io_req_bits_way_en      (req_way_en),
    .io_req_bits_voluntary   (req_vol),
    .io_idx_valid            (idx_valid),
    .io_idx_bits             (idx_bits),
    .io_data_req_valid       (dr_valid),
    .io_data_req_ready       (dr_ready),
    .io_data_req_bits_way_en (dr_way_en),
    .io_data_req_bits_addr   (dr_addr),
    .io_data_resp            (data_resp),
`ifdef WRITEBACK_PARITY_EN
    .io_data_resp_parity     (resp_parity),
    .io_parity_err           (parity_err),
`endif
    .io_mem_c_ready          (c_ready),
    .io_mem_c_valid          (c_valid),
    .io_mem_c_bits_opcode    (c_opcode),
    .io_mem_c_bits_param     (c_param),
    .io_mem_c_bits_size      (c_size),
    .io_mem_c_bits_source    (c_source),
    .io_mem_c_bits_address   (c_address),
    .io_mem_c_bits_data      (c_data),
    .io_mem_c_bits_corrupt   (c_corrupt),
    .io_mem_d_valid          (d_valid),
    .io_mem_d_ready          (d_ready),
    .io_mem_d_bits_opcode    (d_opcode)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Data-array contents for (set, way, beat).
  function automatic logic [63:0] mem_data(input logic [5:0] i, input logic [3:0] w, input int b);
    logic [31:0] hi, lo;
    hi = 32'hC0DE0000 | ({26'd0, i} << 8) | ({28'd0, w} << 4) | 32'(b);
    lo = ~(32'(b) * 32'h01010101);
    return {hi, lo};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Data array: answers a read handshake during the following cycle,
  // otherwise drives garbage so a stray capture is caught.
  always begin : array_model
    logic f;
    logic [8:0] a;
    logic [3:0] w;
    @(negedge clock);
    f = dr_valid && dr_ready && reset;
    a = dr_addr;
    w = dr_way_en;
    @(posedge clock);
    #1;
    if (f) data_resp = mem_data(a[8:3], w, int'(a[2:0]));
    else   data_resp = {$urandom, $urandom};
`ifdef WRITEBACK_PARITY_EN
    resp_parity = (^data_resp) ^ (f && (bad_beat == int'(a[2:0])));
`endif
  end

  always begin : c_ready_drv
    @(posedge clock);
    #1;
    c_ready = c_toggle ? ~c_ready : 1'b1;
  end

  // Scoreboard: expected beat nb is array data (exp_idx, exp_way, nb).
  always begin : scoreboard
    logic        hold_v;
    logic [63:0] hold_data;
    logic [44:0] hold_ctl;
    logic        exp_cor;
    hold_v = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        hold_v = 1'b0;
      end else begin
        chk("idx_valid_vs_ready", idx_valid, !req_ready);
        if (c_valid && hold_v) begin
          chk("c_stable_data", c_data, hold_data);
          chk("c_stable_ctl", {c_opcode, c_param, c_size, c_source, c_address, c_corrupt}, hold_ctl);
        end
        if (c_valid && c_ready) begin
          if (!exp_active || nb >= 8) begin
            chk("c_extra_beat", 1'b1, 1'b0);
          end else begin
`ifdef WRITEBACK_PARITY_EN
            exp_cor = (nb == bad_beat);
`else
            exp_cor = 1'b0;
`endif
            chk("c_data", c_data, mem_data(exp_idx, exp_way, nb));
            chk("c_opcode", c_opcode, exp_vol ? 3'h7 : 3'h5);
            chk("c_param_size_src", {c_param, c_size, c_source}, {exp_param, 4'd6, exp_src});
            chk("c_address", c_address, {exp_tag, exp_idx, 6'b0});
            chk("c_corrupt", c_corrupt, exp_cor);
            if (nb == 0) begin
              first_data = c_data;
              first_addr = c_address;
              first_op   = c_opcode;
            end
            beat_cyc[nb] = cyc;
            nb++;
          end
        end
        hold_v    = c_valid && !c_ready;
        hold_data = c_data;
        hold_ctl  = {c_opcode, c_param, c_size, c_source, c_address, c_corrupt};
        if (dr_valid && dr_ready) begin
          chk("data_req_addr", dr_addr, {exp_idx, 3'(nr)});
          chk("data_req_way", dr_way_en, exp_way);
          nr++;
        end
        chk("reads_ahead_le2", (nr - nb) <= 2, 1'b1);
`ifdef WRITEBACK_PARITY_EN
        if (parity_err) perr_cnt++;
`endif
      end
    end
  end

  task automatic start_req(input logic [19:0] t, input logic [5:0] i, input logic [1:0] s,
                           input logic [2:0] p, input logic [3:0] w, input logic v);
    exp_tag = t; exp_idx = i; exp_src = s; exp_param = p; exp_way = w; exp_vol = v;
    nb = 0; nr = 0; perr_cnt = 0; exp_active = 1'b1;
    req_tag = t; req_idx = i; req_source = s; req_param = p; req_way_en = w; req_vol = v;
    req_valid = 1'b1;
    acc = cyc;
    chk("req_ready_idle", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    chk("req_ready_busy", req_ready, 1'b0);
    chk("idx_bits_latched", idx_bits, i);
  endtask

  task automatic wait_beats(input string name);
    int n;
    n = 0;
    while (nb < 8 && n < 200) begin
      step();
      n++;
    end
    chk(name, nb, 8);
  endtask

  initial begin : main
    int n;
    req_valid = 0; req_tag = 0; req_idx = 0; req_source = 0; req_param = 0;
    req_way_en = 0; req_vol = 0; dr_ready = 0; d_valid = 0; d_opcode = 0;
    c_ready = 1'b1; data_resp = '0;
`ifdef WRITEBACK_PARITY_EN
    resp_parity = 1'b0;
`endif
    step();
    step();
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_outputs", {c_valid, dr_valid, idx_valid, d_ready, idx_bits, dr_addr, dr_way_en},
        '0);
    chk("rst_c_bits", {c_opcode, c_param, c_size, c_source, c_address, c_corrupt}, '0);
    reset = 1'b1;
    #1;
    chk("rst_release_ready", req_ready, 1'b1);
    dr_ready = 1'b1;
    step();

    // Probe, all readies high.
    start_req(20'h12345, 6'h2A, 2'd1, 3'h1, 4'b0001, 1'b0);
    wait_beats("probe_beats");
    chk("probe_first_beat_cyc", beat_cyc[0] - acc, 2);
    chk("probe_last_beat_cyc", beat_cyc[7] - acc, 9);
    chk("probe_addr_literal", first_addr, 32'h1234_5A80);
    chk("probe_data_literal", first_data, 64'hC0DE2A10_FFFFFFFF);
    chk("probe_opcode_literal", first_op, 3'h5);
    while (cyc < acc + 10) step();
    chk("probe_idle_cyc10", req_ready, 1'b1);
    exp_active = 1'b0;
    step();

    // Voluntary release, then ReleaseAck handshake.
    start_req(20'hABCDE, 6'h15, 2'd2, 3'h2, 4'b0100, 1'b1);
    wait_beats("vol_beats");
    step();
    chk("vol_wait_ack", {req_ready, d_ready, idx_valid}, 3'b011);
    d_valid = 1'b1; d_opcode = 3'h4;
    step();
    chk("vol_other_d_ignored", {req_ready, d_ready}, 2'b01);
    d_opcode = 3'h6;
    step();
    d_valid = 1'b0;
    chk("vol_ack_idle", {req_ready, d_ready}, 2'b10);
    exp_active = 1'b0;
    step();

    // C backpressure: c_ready toggles every cycle.
    c_toggle = 1'b1;
    start_req(20'h00F0F, 6'h3F, 2'd3, 3'h0, 4'b1000, 1'b0);
    wait_beats("toggle_beats");
    c_toggle = 1'b0;
    repeat (4) step();
    chk("toggle_no_extra", nb, 8);
    chk("toggle_idle", req_ready, 1'b1);
    exp_active = 1'b0;

    // Data-array stall of 3 cycles before beat 4 is read.
    start_req(20'h55555, 6'h01, 2'd0, 3'h4, 4'b0010, 1'b0);
    n = 0;
    while (nr < 4 && n < 50) begin step(); n++; end
    chk("stall_reach_beat4", nr, 4);
    dr_ready = 1'b0;
    repeat (3) step();
    dr_ready = 1'b1;
    wait_beats("stall_beats");
    chk("stall_c_gap", (beat_cyc[4] - beat_cyc[3]) > 1, 1'b1);
    step();
    step();
    exp_active = 1'b0;

    // Reset mid-transfer at beat 3, then a clean message.
    start_req(20'h0BEEF, 6'h10, 2'd1, 3'h3, 4'b0001, 1'b0);
    n = 0;
    while (nb < 3 && n < 50) begin step(); n++; end
    chk("rst_reach_beat3", nb, 3);
    #2;
    reset = 1'b0;
    exp_active = 1'b0;
    #1;
    chk("midrst_outputs", {req_ready, c_valid, dr_valid, idx_valid, d_ready}, 5'b0);
    chk("midrst_c_bits", {c_opcode, c_param, c_size, c_source, c_address, c_corrupt}, '0);
    step();
    step();
    chk("midrst_held", {c_valid, dr_valid}, 2'b0);
    reset = 1'b1;
    step();
    step();
    start_req(20'h7A7A7, 6'h22, 2'd2, 3'h5, 4'b0100, 1'b0);
    wait_beats("post_rst_beats");
    step();
    step();
    chk("post_rst_idle", req_ready, 1'b1);
    exp_active = 1'b0;

`ifdef WRITEBACK_PARITY_EN
    // Bad parity on beat 5 only.
    bad_beat = 5;
    start_req(20'h13579, 6'h0C, 2'd3, 3'h6, 4'b1000, 1'b0);
    wait_beats("parity_beats");
    step();
    chk("parity_err_pulses", perr_cnt, 1);
    exp_active = 1'b0;
    bad_beat = -1;
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
